// File: rtl/arm_barrel_shifter.sv
// ARM operand-2 barrel shifter: LSL/LSR/ASR/ROR/RRX in immediate and register forms,
// with ARM shifter carry-out, result and carry registered on the rising clock edge.
module arm_barrel_shifter (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:1]  SHIFT_OP,
  input  logic [32:1] Shift_Data,
  input  logic [8:1]  Shift_Num,
  input  logic        Carry_flag,
  output logic [32:1] Shift_Out,
  output logic        Shift_Carry_Out
);

  typedef enum logic [1:0] {
    SH_LSL = 2'd0,
    SH_LSR = 2'd1,
    SH_ASR = 2'd2,
    SH_ROR = 2'd3
  } shift_kind_e;

  logic [31:0] d;
  logic [7:0]  amt;
  logic [4:0]  sh;
  logic        reg_form;
  logic        amt_zero;
  logic        amt_is_32;
  logic        amt_lt_32;
  shift_kind_e kind;

  assign d        = Shift_Data;
  assign reg_form = SHIFT_OP[1];
  assign kind     = shift_kind_e'(SHIFT_OP[3:2]);

  // Immediate forms only see the low five amount bits.
  assign amt       = reg_form ? Shift_Num : {3'b000, Shift_Num[5:1]};
  assign sh        = amt[4:0];
  assign amt_zero  = (amt == 8'd0);
  assign amt_is_32 = (amt == 8'd32);
  assign amt_lt_32 = (amt[7:5] == 3'b000);

  // Each wide result carries one extra bit that holds the last bit shifted out.
  logic        [32:0] lsl_wide;
  logic        [32:0] lsr_wide;
  logic signed [32:0] asr_wide;
  logic        [63:0] ror_wide;

  assign lsl_wide = {1'b0, d} << sh;
  assign lsr_wide = {d, 1'b0} >> sh;
  assign asr_wide = $signed({d, 1'b0}) >>> sh;
  assign ror_wide = {d, d} >> sh;

  logic [31:0] res;
  logic        res_carry;

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    res       = d;
    res_carry = Carry_flag;
    unique case (kind)
      SH_LSL: begin
        if (!amt_zero) begin
          if (amt_lt_32) begin
            {res_carry, res} = lsl_wide;
          end else if (amt_is_32) begin
            res       = '0;
            res_carry = d[0];
          end else begin
            res       = '0;
            res_carry = 1'b0;
          end
        end
      end
      SH_LSR: begin
        // Immediate amount 0 stands for LSR #32.
        if ((amt_zero && !reg_form) || amt_is_32) begin
          res       = '0;
          res_carry = d[31];
        end else if (!amt_zero) begin
          if (amt_lt_32) begin
            {res, res_carry} = lsr_wide;
          end else begin
            res       = '0;
            res_carry = 1'b0;
          end
        end
      end
      SH_ASR: begin
        if ((amt_zero && !reg_form) || (!amt_zero && !amt_lt_32)) begin
          res       = {32{d[31]}};
          res_carry = d[31];
        end else if (!amt_zero) begin
          {res, res_carry} = asr_wide;
        end
      end
      SH_ROR: begin
        if (amt_zero && !reg_form) begin
          // RRX: rotate right by one through the incoming carry.
          res       = {Carry_flag, d[31:1]};
          res_carry = d[0];
        end else if (!amt_zero) begin
          if (sh == 5'd0) begin
            res       = d;
            res_carry = d[31];
          end else begin
            res       = ror_wide[31:0];
            res_carry = ror_wide[31];
          end
        end
      end
      default: begin
        res       = d;
        res_carry = Carry_flag;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Shift_Out       <= '0;
      Shift_Carry_Out <= 1'b0;
    end else begin
      Shift_Out       <= res;
      Shift_Carry_Out <= res_carry;
    end
  end

endmodule

// File: tb/tb_arm_barrel_shifter.sv
// Self-checking bench for arm_barrel_shifter: directed vectors and randomized
// back-to-back operations checked against an arithmetic reference model.
module tb_arm_barrel_shifter;

  logic        clk;
  logic        rst;
  logic [3:1]  SHIFT_OP;
  logic [32:1] Shift_Data;
  logic [8:1]  Shift_Num;
  logic        Carry_flag;
  logic [32:1] Shift_Out;
  logic        Shift_Carry_Out;

  int n_checks = 0;
  int n_pass   = 0;

  arm_barrel_shifter dut (
    .clk             (clk),
    .rst             (rst),
    .SHIFT_OP        (SHIFT_OP),
    .Shift_Data      (Shift_Data),
    .Shift_Num       (Shift_Num),
    .Carry_flag      (Carry_flag),
    .Shift_Out       (Shift_Out),
    .Shift_Carry_Out (Shift_Carry_Out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Reference model: returns {carry, result}, worked out with 64-bit arithmetic.
  function automatic logic [32:0] ref_shift(input logic [2:0] op, input logic [31:0] d,
                                            input logic [7:0] num, input logic c);
    int unsigned n;
    int unsigned k;
    logic [63:0] t;
    logic signed [63:0] s;
    logic [31:0] r;
    n = op[0] ? int'(num) : int'(num[4:0]);
    case (op[2:1])
      2'd0: begin
        if (n == 0) return {c, d};
        t = {32'b0, d} << n;
        return {t[32], t[31:0]};
      end
      2'd1: begin
        k = (!op[0] && n == 0) ? 32 : n;
        if (k == 0) return {c, d};
        t = {d, 32'b0} >> k;
        return {t[31], t[63:32]};
      end
      2'd2: begin
        k = (!op[0] && n == 0) ? 32 : n;
        if (k == 0) return {c, d};
        if (k > 32) k = 32;
        s = {d, 32'b0};
        s = s >>> k;
        return {s[31], s[63:32]};
      end
      default: begin
        if (n == 0) return op[0] ? {c, d} : {d[0], c, d[31:1]};
        k = n % 32;
        if (k == 0) return {d[31], d};
        r = (d >> k) | (d << (32 - k));
        return {r[31], r};
      end
    endcase
  endfunction

  task automatic check_out(input string tag, input logic [31:0] exp_out, input logic exp_c);
    n_checks++;
    assert (Shift_Out === exp_out) n_pass++;
    else $error("FAIL %s: Shift_Out=%h expected %h", tag, Shift_Out, exp_out);
    n_checks++;
    assert (Shift_Carry_Out === exp_c) n_pass++;
    else $error("FAIL %s: Shift_Carry_Out=%b expected %b", tag, Shift_Carry_Out, exp_c);
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] d, input logic [7:0] num,
                       input logic c);
    SHIFT_OP   = op;
    Shift_Data = d;
    Shift_Num  = num;
    Carry_flag = c;
  endtask

  // Apply one operation, clock it, and compare one step after the edge.
  task automatic step(input string tag, input logic [2:0] op, input logic [31:0] d,
                      input logic [7:0] num, input logic c);
    logic [32:0] e;
    drive(op, d, num, c);
    e = ref_shift(op, d, num, c);
    @(posedge clk);
    #1;
    check_out(tag, e[31:0], e[32]);
  endtask

  initial begin
    logic [32:0] e;
    logic [2:0]  rop;
    logic [31:0] rd;
    logic [7:0]  rn;
    logic        rc;

    rst = 1'b1;
    drive(3'b000, 32'h0, 8'd0, 1'b0);
    @(posedge clk);
    #1;
    check_out("reset_hold", 32'h0, 1'b0);

    // Asynchronous reset arriving mid-operation.
    rst = 1'b0;
    step("pre_reset_op", 3'b101, 32'h8A9D029D, 8'd40, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_out("async_reset", 32'h0, 1'b0);
    @(posedge clk);
    #1;
    check_out("reset_over_edge", 32'h0, 1'b0);
    rst = 1'b0;

    step("lsl_imm_n0",    3'b000, 32'h773D8F5C, 8'd0,  1'b0);
    step("lsl_reg_3",     3'b001, 32'h3AC50001, 8'd3,  1'b0);
    step("lsl_imm_35",    3'b000, 32'h87654321, 8'd35, 1'b0);
    step("lsl_reg_32",    3'b001, 32'h00000001, 8'd32, 1'b0);
    step("lsl_reg_33",    3'b001, 32'hFFFFFFFF, 8'd33, 1'b1);
    step("lsr_imm_0",     3'b010, 32'hF0000000, 8'd0,  1'b0);
    step("lsr_reg_12",    3'b011, 32'h5F5555F5, 8'd12, 1'b0);
    step("lsr_reg_31",    3'b011, 32'hFFFFFFFF, 8'd31, 1'b0);
    step("lsr_imm_32",    3'b010, 32'hFFFFFFFF, 8'd32, 1'b0);
    step("lsr_reg_33",    3'b011, 32'hFFFFFFFF, 8'd33, 1'b0);
    step("asr_imm_0",     3'b100, 32'h7A9D029D, 8'd0,  1'b0);
    step("asr_reg_0",     3'b101, 32'h8A9D029D, 8'd0,  1'b0);
    step("asr_imm_6",     3'b100, 32'h8A9D029D, 8'd6,  1'b0);
    step("asr_reg_40",    3'b101, 32'h8A9D029D, 8'd40, 1'b1);
    step("rrx",           3'b110, 32'h999FF999, 8'd0,  1'b1);
    step("ror_reg_0",     3'b111, 32'h12345678, 8'd0,  1'b1);
    step("ror_imm_1",     3'b110, 32'h3F3F3F3F, 8'd1,  1'b0);
    step("ror_reg_39",    3'b111, 32'h1F2F3F4F, 8'd39, 1'b0);
    step("ror_reg_64",    3'b111, 32'h80000001, 8'd64, 1'b0);
    step("lsl_reg_255",   3'b001, 32'hFFFFFFFF, 8'd255, 1'b1);

    // Hand-derived values for two vectors, independent of the model.
    step("asr_imm_6_gold", 3'b100, 32'h8A9D029D, 8'd6, 1'b0);
    check_out("asr_imm_6_const", 32'hFE2A740A, 1'b0);
    step("ror_reg_39_gold", 3'b111, 32'h1F2F3F4F, 8'd39, 1'b0);
    check_out("ror_reg_39_const", 32'h9E3E5E7E, 1'b1);

    // Inputs changing between edges must not reach the outputs.
    e = ref_shift(3'b111, 32'h1F2F3F4F, 8'd39, 1'b0);
    drive(3'b001, 32'hDEADBEEF, 8'd4, 1'b1);
    #2;
    check_out("hold_between_edges", e[31:0], e[32]);
    @(posedge clk);
    #1;
    e = ref_shift(3'b001, 32'hDEADBEEF, 8'd4, 1'b1);
    check_out("after_edge", e[31:0], e[32]);

    // Randomized back-to-back operations: a new operation every cycle.
    for (int i = 0; i < 400; i++) begin
      rop = 3'($urandom_range(0, 7));
      rd  = $urandom;
      rc  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: rn = 8'd0;
        1: rn = 8'd1;
        2: rn = 8'd31;
        3: rn = 8'd32;
        4: rn = 8'd33;
        5: rn = 8'(32 * $urandom_range(0, 7));
        default: rn = 8'($urandom);
      endcase
      step("random", rop, rd, rn, rc);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
